// File: rtl/board_pkg.sv
// Shared definitions for the front-panel controller: clock-enable modes and
// the divide ratio attached to each mode.
package board_pkg;

  localparam int DIV_W = 17;

  typedef enum logic [2:0] {
    MODE_FULL    = 3'd0,
    MODE_DIV2    = 3'd1,
    MODE_DIV10   = 3'd2,
    MODE_DIV100  = 3'd3,
    MODE_DIV1K   = 3'd4,
    MODE_DIV10K  = 3'd5,
    MODE_DIV100K = 3'd6,
    MODE_STEP    = 3'd7
  } mode_e;

  // Ratio is only meaningful for the divide modes; STEP returns 0.
  function automatic logic [DIV_W-1:0] ce_ratio(input mode_e mode);
    case (mode)
      MODE_FULL:    ce_ratio = DIV_W'(1);
      MODE_DIV2:    ce_ratio = DIV_W'(2);
      MODE_DIV10:   ce_ratio = DIV_W'(10);
      MODE_DIV100:  ce_ratio = DIV_W'(100);
      MODE_DIV1K:   ce_ratio = DIV_W'(1000);
      MODE_DIV10K:  ce_ratio = DIV_W'(10000);
      MODE_DIV100K: ce_ratio = DIV_W'(100000);
      default:      ce_ratio = '0;
    endcase
  endfunction

endpackage

// File: rtl/board_io_ctrl_if.sv
// Front-panel signal bundle: raw buttons/switches in, debounced levels,
// edge pulses, control register and processor clock enable out.
interface board_io_ctrl_if #(
  parameter int NBTN   = 4,
  parameter int NSW    = 8,
  parameter int CTRL_W = 8
);
  logic [NBTN-1:0]   btn;
  logic [NSW-1:0]    sw;
  logic [NBTN-1:0]   btn_db;
  logic [NBTN-1:0]   btn_rise;
  logic [NSW-1:0]    sw_db;
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_wr;
  logic              tick;
  logic              cpu_ce;

  modport master (
    output btn, sw,
    input  btn_db, btn_rise, sw_db, ctrl, ctrl_wr, tick, cpu_ce
  );

  modport slave (
    input  btn, sw,
    output btn_db, btn_rise, sw_db, ctrl, ctrl_wr, tick, cpu_ce
  );
endinterface

// File: rtl/debounce_cell.sv
// One input bit: two-flop synchroniser followed by a tick-sampled run-length
// debouncer that accepts a new level after DB_SAMPLES consecutive samples.
module debounce_cell #(
  parameter int DB_SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic db
);
  localparam int CNT_W = $clog2(DB_SAMPLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      run_cnt <= '0;
      db      <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // A sample matching db breaks the run, so a bounce restarts the count.
      if (tick) begin
        if (sync_p1 == db) begin
          run_cnt <= '0;
        end else if (run_cnt == CNT_W'(DB_SAMPLES - 1)) begin
          db      <= sync_p1;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// Front-panel controller: sample tick, per-bit debouncers, button edge pulses,
// armed control-register load and single-domain processor clock enable.
module board_io_ctrl
  import board_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SAMPLE_HZ  = 100,
  parameter int DB_SAMPLES = 3,
  parameter int NBTN       = 4,
  parameter int NSW        = 8,
  parameter int CTRL_W     = 8,
  parameter int LOAD_BTN   = 1,
  parameter int ARM_BTN    = 2,
  parameter int STEP_BTN   = 0
) (
  input  logic           clk,
  input  logic           reset,
  board_io_ctrl_if.slave io
);
  localparam int TP     = CLK_HZ / SAMPLE_HZ;
  localparam int TCNT_W = $clog2(TP);

  logic [TCNT_W-1:0] tcnt;
  logic              tick;
  logic [NBTN-1:0]   btn_db;
  logic [NBTN-1:0]   btn_db_q;
  logic [NBTN-1:0]   btn_rise;
  logic [NSW-1:0]    sw_db;
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_wr;
  logic              ce_en;
  logic              chg_p0;
  logic              chg_p1;
  logic              step_ce;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  ratio;
  mode_e             mode;
  mode_e             new_mode;
  logic              load;
  logic              mode_chg;
  logic              div_mode;
  logic              hold;
  logic              div_hit;
  logic              cpu_ce;

  // ---- sample tick
  always_ff @(posedge clk) begin
    if (reset || tick) tcnt <= '0;
    else               tcnt <= tcnt + TCNT_W'(1);
  end

  assign tick = (tcnt == TCNT_W'(TP - 1));

  // ---- synchronise + debounce, one cell per bit
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce_cell #(.DB_SAMPLES(DB_SAMPLES)) u_cell (
      .clk(clk), .reset(reset), .tick(tick), .din(io.btn[i]), .db(btn_db[i])
    );
  end

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    debounce_cell #(.DB_SAMPLES(DB_SAMPLES)) u_cell (
      .clk(clk), .reset(reset), .tick(tick), .din(io.sw[i]), .db(sw_db[i])
    );
  end

  // ---- edge detect, load decode, divider compare
  always_comb begin
    btn_rise = btn_db & ~btn_db_q;
    mode     = mode_e'(ctrl[2:0]);
    new_mode = mode_e'(sw_db[2:0]);
    load     = btn_rise[LOAD_BTN] & btn_db[ARM_BTN];
    // The first load after reset always counts as a mode change.
    mode_chg = load & (~ce_en | (new_mode != mode));
    ratio    = ce_ratio(mode);
    div_mode = (mode != MODE_FULL) && (mode != MODE_STEP);
    hold     = chg_p0 | chg_p1;
    div_hit  = div_mode && (div_cnt == ratio - DIV_W'(1));
    // The step pulse bypasses the hold so a press coinciding with a load
    // still issues under the old mode.
    cpu_ce   = step_ce | (ce_en & ~hold & ((mode == MODE_FULL) | div_hit));
  end

  // ---- ctrl register and clock-enable state
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db_q <= '0;
      ctrl     <= '0;
      ctrl_wr  <= 1'b0;
      ce_en    <= 1'b0;
      chg_p0   <= 1'b0;
      chg_p1   <= 1'b0;
      step_ce  <= 1'b0;
      div_cnt  <= '0;
    end else begin
      btn_db_q <= btn_db;
      ctrl_wr  <= load;
      chg_p0   <= mode_chg;
      chg_p1   <= chg_p0;
      step_ce  <= ce_en & (mode == MODE_STEP) & btn_rise[STEP_BTN];
      if (load) begin
        ctrl  <= sw_db[CTRL_W-1:0];
        ce_en <= 1'b1;
      end
      if (mode_chg || hold || !ce_en || !div_mode || div_hit) div_cnt <= '0;
      else                                                    div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign io.tick     = tick;
  assign io.btn_db   = btn_db;
  assign io.btn_rise = btn_rise;
  assign io.sw_db    = sw_db;
  assign io.ctrl     = ctrl;
  assign io.ctrl_wr  = ctrl_wr;
  assign io.cpu_ce   = cpu_ce;

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised front-panel controller for the P12 board top levels. It debounces NBTN buttons and NSW switches on a sample tick derived from the system clock, and produces one-cycle rising-edge pulses. It loads a CTRL_W-bit control register from the switches on an armed button press. From control bits [2:0] it generates a single-domain processor clock enable (fixed divide ratios or manual single-step), so no clock multiplexing or extra BUFGs are needed.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- SAMPLE_HZ, 100, debounce sample rate; tick period TP = CLK_HZ/SAMPLE_HZ cycles (integer, ≥2)
- DB_SAMPLES, 3, consecutive equal samples required to accept a new level (≥1)
- NBTN, 4, button count (≥3)
- NSW, 8, switch count
- CTRL_W, 8, control register width (≥3, ≤NSW)
- LOAD_BTN, 1, button index that strobes ctrl load
- ARM_BTN, 2, button index that must be held for load
- STEP_BTN, 0, button index used for single-step
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- btn  in  NBTN  raw buttons
- sw  in  NSW  raw switches
- btn_db  out  NBTN  debounced buttons
- btn_rise  out  NBTN  one-cycle pulse on 0→1 of btn_db
- sw_db  out  NSW  debounced switches
- ctrl  out  CTRL_W  control register
- ctrl_wr  out  1  one-cycle pulse when ctrl is loaded
- tick  out  1  one-cycle sample tick
- cpu_ce  out  1  processor clock enable

## Operation
- Synchroniser: 2 FFs per input bit, reset to 0.
- Tick counter: 0..TP-1, wraps; tick=1 in the cycle the counter equals TP-1.
- Debounce cell per bit, evaluated only on tick:
  - Sampled value equals current db → run counter cleared.
  - Value differs → run counter increments; when it reaches DB_SAMPLES, db takes the sampled value and the counter clears.
  - Counter width is clog2(DB_SAMPLES+1).
- btn_rise[i] = btn_db[i] & ~btn_db_q[i], where btn_db_q is a 1-cycle delayed copy.
- Ctrl load: when btn_rise[LOAD_BTN] && btn_db[ARM_BTN], then ctrl ← sw_db[CTRL_W-1:0] and ctrl_wr=1 in the same cycle as the register update. LOAD pressed without ARM is ignored.
- Clock-enable modes, selected by ctrl[2:0]:
  - 0: cpu_ce=1 every cycle.
  - 1: divide by 2.
  - 2..6: divide by 10^(mode-1), i.e. 10, 100, 1000, 10000, 100000.
  - 7: cpu_ce = btn_rise[STEP_BTN].
  - Divider counter is 17 bits. In divide modes, cpu_ce=1 in the cycle the counter equals ratio-1; the counter then wraps to 0.
- Mode change (ctrl_wr with a different [2:0]): divider counter cleared. cpu_ce=0 in the ctrl_wr cycle and the following cycle, then counting restarts from 0.

## Timing
- Reset values: all outputs 0, counters 0, synchronisers 0.
- Raw edge → synchroniser output: 2 cycles.
- Debounce: db changes in the cycle after the DB_SAMPLES-th consecutive differing tick sample.
- Worst-case latency: 2 + DB_SAMPLES·TP + 1 cycles.
- btn_rise is asserted the cycle after btn_db rises.
- ctrl and ctrl_wr are registered one cycle after btn_rise.
- Step mode: cpu_ce is registered from btn_rise, 1-cycle latency, exactly one pulse per press.
- A glitch shorter than DB_SAMPLES ticks never changes db. A bounce back to the db value clears the run counter.
- Simultaneous STEP_BTN and LOAD_BTN rise in mode 7: the step pulse is issued under the old mode, then the new mode applies.
- Reset mid-debounce or mid-divide: all state cleared in the next cycle, with no residual pulses.
- In STEP mode, the divider counter is held at 0.

## Structure
- Package board_pkg:
  - mode constants MODE_FULL=0, MODE_DIV2=1, MODE_STEP=7
  - function ce_ratio(mode) returning a 17-bit ratio
  - localparam DIV_W=17
- Sub-module debounce_cell, containing the synchroniser, run counter and db register. It is instantiated once per btn/sw bit via generate and shares the top-level tick.
- Top level holds the tick counter, edge detect, ctrl register and CE divider.

## Test plan
- Use CLK_HZ=1000, SAMPLE_HZ=100 (TP=10), DB_SAMPLES=3.
- Reset → all outputs 0. tick pulses at cycles 9, 19, 29…
- btn[3] held high → btn_db[3] rises within 2+30+1 cycles. btn_rise[3] is exactly 1 cycle. A 15-cycle pulse on btn[3] produces no btn_db change.
- sw=8'hA5, press btn[1] without btn[2] → ctrl stays 0. Hold btn[2], press btn[1] → ctrl=8'hA5, single ctrl_wr pulse.
- Load ctrl=8'h03 (÷100) → cpu_ce period 100 cycles. Load 8'h00 → cpu_ce continuously 1 after the 2-cycle gap.
- Load ctrl=8'h07, press btn[0] three times → exactly three single-cycle cpu_ce pulses and no others.
- Assert reset mid-count in mode 2 → cpu_ce, ctrl, btn_db at 0 next cycle. After release, the first cpu_ce occurs only after a new load.
